// File: rtl/mem_arbiter.sv
// Arbitrates one fixed-latency unified memory port between instruction fetch and load/store.
// Data wins by default; fetch is forced through after STARVE_LIMIT consecutive data grants.
module mem_arbiter #(
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_if_req,
  input  logic [15:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_valid,
  output logic [31:0] o_if_instr,
  input  logic        i_d_req,
  input  logic        i_d_we,
  input  logic [15:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  input  logic [1:0]  i_d_size,
  input  logic        i_d_signed,
  output logic        o_d_gnt,
  output logic        o_d_valid,
  output logic [31:0] o_d_rdata,
  output logic        o_d_err,
  output logic        o_m_we,
  output logic [15:0] o_m_addr,
  output logic [31:0] o_m_wdata,
  output logic [1:0]  o_m_size,
  output logic        o_m_signed,
  input  logic [31:0] i_m_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ERR} state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_cnt, r_starve;
  logic        r_own_d, r_store;
  logic        r_if_valid, r_d_valid, r_d_err, r_m_we, r_m_signed;
  logic [31:0] r_if_instr, r_d_rdata, r_m_wdata;
  logic [15:0] r_m_addr;
  logic [1:0]  r_m_size;
  logic        w_if_win, w_d_win, w_d_ill, w_last;

  // Grants are gated by reset so nothing is offered while a reset is being sampled.
  always_comb begin
    w_next   = r_state;
    w_if_win = 1'b0;
    w_d_win  = 1'b0;
    w_last   = (r_cnt == 4'(MEM_LATENCY));
    w_d_ill  = (i_d_size == 2'b11);
    case (r_state)
      S_IDLE: if (i_rst_n) begin
        if (i_if_req && (!i_d_req || r_starve == 4'(STARVE_LIMIT))) begin
          w_if_win = 1'b1;
          w_next   = S_BUSY;
        end else if (i_d_req) begin
          w_d_win = 1'b1;
          w_next  = w_d_ill ? S_ERR : S_BUSY;
        end
      end
      S_BUSY:  if (w_last) w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt      <= '0;
      r_starve   <= '0;
      r_own_d    <= 1'b0;
      r_store    <= 1'b0;
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      r_d_err    <= 1'b0;
      r_if_instr <= '0;
      r_d_rdata  <= '0;
      r_m_we     <= 1'b0;
      r_m_addr   <= '0;
      r_m_wdata  <= '0;
      r_m_size   <= '0;
      r_m_signed <= 1'b0;
    end else begin
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      r_d_err    <= 1'b0;

      if (w_if_win) begin
        r_m_addr   <= i_if_addr;
        r_m_size   <= 2'b10;
        r_m_signed <= 1'b0;
        r_m_we     <= 1'b0;
        r_own_d    <= 1'b0;
        r_store    <= 1'b0;
        r_cnt      <= 4'd1;
      end else if (w_d_win) begin
        if (w_d_ill) begin
          // Illegal size never reaches memory; the error response is registered here.
          r_d_valid <= 1'b1;
          r_d_err   <= 1'b1;
        end else begin
          r_m_addr   <= i_d_addr;
          r_m_wdata  <= i_d_wdata;
          r_m_size   <= i_d_size;
          r_m_signed <= i_d_signed;
          r_m_we     <= i_d_we;
          r_own_d    <= 1'b1;
          r_store    <= i_d_we;
          r_cnt      <= 4'd1;
        end
      end

      if (r_state == S_BUSY) begin
        r_m_we <= 1'b0;
        if (w_last) begin
          if (r_own_d) begin
            r_d_valid <= 1'b1;
            if (!r_store) r_d_rdata <= i_m_rdata;
          end else begin
            r_if_valid <= 1'b1;
            r_if_instr <= i_m_rdata;
          end
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
      end

      if (w_if_win)
        r_starve <= '0;
      else if (r_state == S_IDLE && !i_if_req)
        r_starve <= '0;
      else if (w_d_win && i_if_req && r_starve != 4'(STARVE_LIMIT))
        r_starve <= r_starve + 4'd1;
    end
  end

  assign o_if_gnt   = w_if_win;
  assign o_d_gnt    = w_d_win;
  assign o_if_valid = r_if_valid;
  assign o_if_instr = r_if_instr;
  assign o_d_valid  = r_d_valid;
  assign o_d_rdata  = r_d_rdata;
  assign o_d_err    = r_d_err;
  assign o_m_we     = r_m_we;
  assign o_m_addr   = r_m_addr;
  assign o_m_wdata  = r_m_wdata;
  assign o_m_size   = r_m_size;
  assign o_m_signed = r_m_signed;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: latency-1 fetch instance plus a latency-3 instance
// exercising stores, signed loads, starvation order, illegal size and reset mid-access.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int total = 0;
  int bad   = 0;

  // ---- latency-1 instance (fetch only) ----
  logic        if1_req, if1_gnt, if1_valid;
  logic [15:0] if1_addr;
  logic [31:0] if1_instr;
  logic        d1_req, d1_we, d1_sg, d1_gnt, d1_valid, d1_err;
  logic [15:0] d1_addr;
  logic [31:0] d1_wd, d1_rdata;
  logic [1:0]  d1_sz;
  logic        m1_we, m1_sg;
  logic [15:0] m1_addr;
  logic [31:0] m1_wdata, m1_rdata;
  logic [1:0]  m1_size;
  bit   [7:0]  mem1 [0:65535];

  // ---- latency-3 instance ----
  logic        if3_req, if3_gnt, if3_valid;
  logic [15:0] if3_addr;
  logic [31:0] if3_instr;
  logic        d_req, d_we, d_sg, d_gnt, d_valid, d_err;
  logic [15:0] d_addr;
  logic [31:0] d_wd, d_rdata;
  logic [1:0]  d_sz;
  logic        m3_we, m3_sg;
  logic [15:0] m3_addr;
  logic [31:0] m3_wdata, m3_rdata;
  logic [1:0]  m3_size;
  bit   [7:0]  mem3 [0:65535];

  mem_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(if1_req), .i_if_addr(if1_addr), .o_if_gnt(if1_gnt),
    .o_if_valid(if1_valid), .o_if_instr(if1_instr),
    .i_d_req(d1_req), .i_d_we(d1_we), .i_d_addr(d1_addr), .i_d_wdata(d1_wd),
    .i_d_size(d1_sz), .i_d_signed(d1_sg), .o_d_gnt(d1_gnt), .o_d_valid(d1_valid),
    .o_d_rdata(d1_rdata), .o_d_err(d1_err),
    .o_m_we(m1_we), .o_m_addr(m1_addr), .o_m_wdata(m1_wdata), .o_m_size(m1_size),
    .o_m_signed(m1_sg), .i_m_rdata(m1_rdata));

  mem_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(4)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(if3_req), .i_if_addr(if3_addr), .o_if_gnt(if3_gnt),
    .o_if_valid(if3_valid), .o_if_instr(if3_instr),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wd),
    .i_d_size(d_sz), .i_d_signed(d_sg), .o_d_gnt(d_gnt), .o_d_valid(d_valid),
    .o_d_rdata(d_rdata), .o_d_err(d_err),
    .o_m_we(m3_we), .o_m_addr(m3_addr), .o_m_wdata(m3_wdata), .o_m_size(m3_size),
    .o_m_signed(m3_sg), .i_m_rdata(m3_rdata));

  // Little-endian byte memory; size/sign extension is done on the memory side.
  function automatic logic [31:0] ext(input logic [31:0] w, input logic [1:0] sz, input logic sg);
    case (sz)
      2'b00:   ext = sg ? {{24{w[7]}}, w[7:0]}   : {24'b0, w[7:0]};
      2'b01:   ext = sg ? {{16{w[15]}}, w[15:0]} : {16'b0, w[15:0]};
      default: ext = w;
    endcase
  endfunction

  logic [15:0] a1_1, a1_2, a1_3, a3_1, a3_2, a3_3;
  assign a1_1 = m1_addr + 16'd1;
  assign a1_2 = m1_addr + 16'd2;
  assign a1_3 = m1_addr + 16'd3;
  assign a3_1 = m3_addr + 16'd1;
  assign a3_2 = m3_addr + 16'd2;
  assign a3_3 = m3_addr + 16'd3;

  always_comb m1_rdata = ext({mem1[a1_3], mem1[a1_2], mem1[a1_1], mem1[m1_addr]}, m1_size, m1_sg);
  always_comb m3_rdata = ext({mem3[a3_3], mem3[a3_2], mem3[a3_1], mem3[m3_addr]}, m3_size, m3_sg);

  always @(posedge clk) begin
    if (m3_we) begin
      mem3[m3_addr] <= m3_wdata[7:0];
      if (m3_size != 2'b00) mem3[a3_1] <= m3_wdata[15:8];
      if (m3_size == 2'b10) begin
        mem3[a3_2] <= m3_wdata[23:16];
        mem3[a3_3] <= m3_wdata[31:24];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Issues one data access, then counts cycles from grant to D_VALID (bounded).
  task automatic d_op(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                      input logic [1:0] sz, input logic sg, input string tag);
    int n;
    nxt();
    d_req = 1'b1; d_we = we; d_addr = addr; d_wd = wd; d_sz = sz; d_sg = sg;
    #1;
    chk({tag, "_gnt"}, d_gnt, 1);
    nxt();
    d_req = 1'b0;
    #1;
    n = 1;
    while (!d_valid && n < 30) begin
      nxt();
      #1;
      n++;
    end
    chk({tag, "_lat"}, n, 4);
    chk({tag, "_err"}, d_err, 0);
  endtask

  initial begin
    logic [9:0] seq;
    int g, cyc, n;
    seq = '0;
    rst_n = 1'b0;
    if1_req = 0; if1_addr = '0;
    d1_req = 0; d1_we = 0; d1_sg = 0; d1_addr = '0; d1_wd = '0; d1_sz = '0;
    if3_req = 0; if3_addr = '0;
    d_req = 0; d_we = 0; d_sg = 0; d_addr = '0; d_wd = '0; d_sz = '0;
    mem1[16'h0010] = 8'hEF; mem1[16'h0011] = 8'hBE;
    mem1[16'h0012] = 8'hAD; mem1[16'h0013] = 8'hDE;

    // Reset state
    nxt(); nxt(); #1;
    chk("rst_if_valid", if3_valid, 0);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_m_we", m3_we, 0);
    chk("rst_m_addr", m3_addr, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_if_instr1", if1_instr, 0);

    // Fetch, latency 1
    nxt();
    rst_n = 1'b1; if1_req = 1'b1; if1_addr = 16'h0010;
    #1;
    chk("f1_gnt", if1_gnt, 1);
    nxt(); if1_req = 1'b0; #1;
    chk("f1_m_addr", m1_addr, 32'h0010);
    chk("f1_m_size", m1_size, 2);
    chk("f1_valid_early", if1_valid, 0);
    nxt(); #1;
    chk("f1_valid", if1_valid, 1);
    chk("f1_instr", if1_instr, 32'hDEADBEEF);
    nxt(); #1;
    chk("f1_valid_pulse", if1_valid, 0);

    // Word store, latency 3: one M_WE cycle, D_VALID 4 cycles after grant
    nxt();
    d_req = 1; d_we = 1; d_addr = 16'h0100; d_wd = 32'h12345678; d_sz = 2'b10; d_sg = 0;
    #1;
    chk("st_gnt", d_gnt, 1);
    chk("st_we_idle", m3_we, 0);
    nxt(); d_req = 0; #1;
    chk("st_we1", m3_we, 1);
    chk("st_m_addr", m3_addr, 32'h0100);
    chk("st_m_wdata", m3_wdata, 32'h12345678);
    nxt(); #1;
    chk("st_we2", m3_we, 0);
    chk("st_valid2", d_valid, 0);
    nxt(); #1;
    chk("st_we3", m3_we, 0);
    chk("st_valid3", d_valid, 0);
    nxt(); #1;
    chk("st_valid4", d_valid, 1);
    chk("st_rdata_hold", d_rdata, 0);

    // Loads with sign handling
    d_op(0, 16'h0103, 0, 2'b00, 1, "lb_103");
    chk("lb_103_data", d_rdata, 32'h00000012);
    d_op(0, 16'h0100, 0, 2'b01, 1, "lh_100");
    chk("lh_100_data", d_rdata, 32'h00005678);
    d_op(1, 16'h0104, 32'h00000085, 2'b00, 0, "sb_104");
    chk("sb_104_hold", d_rdata, 32'h00005678);
    d_op(0, 16'h0104, 0, 2'b00, 1, "lb_104s");
    chk("lb_104s_data", d_rdata, 32'hFFFFFF85);
    d_op(0, 16'h0104, 0, 2'b00, 0, "lb_104u");
    chk("lb_104u_data", d_rdata, 32'h00000085);

    // Starvation: both requesters held high continuously
    nxt();
    d_req = 1; d_we = 0; d_addr = 16'h0100; d_sz = 2'b10; d_sg = 0;
    if3_req = 1; if3_addr = 16'h0100;
    g = 0; cyc = 0;
    while (g < 10 && cyc < 200) begin
      #1;
      chk("gnt_excl", {31'b0, if3_gnt & d_gnt}, 0);
      if (if3_gnt || d_gnt) begin
        seq[g] = if3_gnt;
        g++;
      end
      nxt();
      cyc++;
    end
    d_req = 0; if3_req = 0;
    chk("starve_count", g, 10);
    chk("starve_seq", {22'b0, seq}, {22'b0, 10'b1000010000});
    n = 0;
    #1;
    while (!if3_valid && n < 10) begin
      nxt(); #1; n++;
    end
    chk("starve_last_if", if3_valid, 1);
    chk("starve_if_instr", if3_instr, 32'h12345678);
    chk("starve_d_rdata", d_rdata, 32'h12345678);

    // Illegal size
    nxt();
    d_req = 1; d_we = 1; d_addr = 16'h0300; d_wd = 32'hFFFFFFFF; d_sz = 2'b11; d_sg = 0;
    #1;
    chk("ill_gnt", d_gnt, 1);
    chk("ill_we0", m3_we, 0);
    nxt(); d_req = 0; #1;
    chk("ill_valid", d_valid, 1);
    chk("ill_err", d_err, 1);
    chk("ill_we1", m3_we, 0);
    chk("ill_rdata", d_rdata, 32'h12345678);
    chk("ill_m_addr_hold", m3_addr, 32'h0100);
    nxt(); #1;
    chk("ill_valid_pulse", d_valid, 0);
    chk("ill_err_pulse", d_err, 0);
    chk("ill_we2", m3_we, 0);

    // Reset during a store in BUSY, fetch pending
    nxt();
    d_req = 1; d_we = 1; d_addr = 16'h0200; d_wd = 32'hAABBCCDD; d_sz = 2'b10; d_sg = 0;
    #1;
    chk("rb_gnt", d_gnt, 1);
    nxt();
    d_req = 0; if3_req = 1; if3_addr = 16'h0100; rst_n = 0;
    #1;
    chk("rb_we", m3_we, 1);
    chk("rb_if_gnt_busy", if3_gnt, 0);
    nxt(); #1;
    chk("rb_d_valid", d_valid, 0);
    chk("rb_m_we", m3_we, 0);
    chk("rb_m_addr", m3_addr, 0);
    chk("rb_m_wdata", m3_wdata, 0);
    chk("rb_m_size", m3_size, 0);
    chk("rb_d_rdata", d_rdata, 0);
    chk("rb_if_instr", if3_instr, 0);
    chk("rb_gnts", {30'b0, if3_gnt, d_gnt}, 0);
    nxt(); rst_n = 1; #1;
    chk("rb_if_gnt", if3_gnt, 1);
    nxt(); if3_req = 0; #1;
    chk("rb_f_m_addr", m3_addr, 32'h0100);
    chk("rb_f_m_size", m3_size, 2);
    chk("rb_dv1", d_valid, 0);
    nxt(); #1;
    chk("rb_dv2", d_valid, 0);
    nxt(); #1;
    chk("rb_fv3", if3_valid, 0);
    nxt(); #1;
    chk("rb_fv4", if3_valid, 1);
    chk("rb_finstr", if3_instr, 32'h12345678);
    chk("rb_dv4", d_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
